wb_sequencer: RTL and testbench

Write-back sequencer for the multicycle CPU register file. It accepts one write-back request at a time from the main control unit, holds the MemtoReg source selector and destination register stable, and waits for the chosen source to become valid (memory data, HI/LO, shift register). It then issues a single-cycle register-file write and signals completion. It sits between the control FSM and the MemtoReg mux / register bank, and owns `seletor`, `RegWrite` and the write address.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_watchdog.sv | 39 +++
 rtl/wb_sequencer.sv | 110 +++++++++++
 tb/tb_wb_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back sequencer: MemtoReg source codes,
// sequencer states and source classification helpers.
package wb_pkg;

  localparam logic [3:0] WB_ALU     = 4'd0;
  localparam logic [3:0] WB_MDR     = 4'd1;
  localparam logic [3:0] WB_LO      = 4'd2;
  localparam logic [3:0] WB_HI      = 4'd3;
  localparam logic [3:0] WB_SHIFT   = 4'd4;
  localparam logic [3:0] WB_SX16    = 4'd5;
  localparam logic [3:0] WB_SL16    = 4'd6;
  localparam logic [3:0] WB_SX1     = 4'd7;
  localparam logic [3:0] WB_CONST   = 4'd8;
  localparam logic [3:0] WB_A       = 4'd9;
  localparam logic [3:0] WB_B       = 4'd10;
  localparam logic [3:0] WB_SRC_MAX = WB_B;

  // Constant presented by the MemtoReg mux when seletor == WB_CONST.
  localparam logic [31:0] WB_CONST_227 = 32'd227;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_WRITE
  } wb_state_e;

  function automatic logic wb_src_legal(input logic [3:0] src);
    return src <= WB_SRC_MAX;
  endfunction

  // Sources whose value arrives some cycles after the request.
  function automatic logic wb_src_waits(input logic [3:0] src);
    return (src >= WB_MDR) && (src <= WB_SHIFT);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Saturating cycle counter for the write-back WAIT state; flags the cycle in which the
// count would reach TIMEOUT_CYCLES.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] MaxCount  = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != MaxCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted in the last waiting cycle so the abort lands exactly TIMEOUT_CYCLES into WAIT.
  assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: captures one request, waits for its source to become valid and
// issues a single-cycle register-file write, with flush and watchdog abort paths.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [3:0] wb_src,
  input  logic [4:0] wb_dst,
  input  logic       wb_flush,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  input  logic       shift_done,
  output logic       wb_ack,
  output logic       busy,
  output logic [3:0] seletor,
  output logic       reg_write,
  output logic [4:0] write_reg,
  output logic       wb_done,
  output logic       wb_err
);

  wb_state_e  state_q;
  logic [3:0] seletor_q;
  logic [4:0] write_reg_q;
  logic       err_q;
  logic       src_ready;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  always_comb begin
    src_ready = 1'b0;
    case (seletor_q)
      WB_MDR:       src_ready = mem_ready;
      WB_LO, WB_HI: src_ready = muldiv_done;
      WB_SHIFT:     src_ready = shift_done;
      default:      src_ready = 1'b0;
    endcase
  end

  // Count stays at zero outside WAIT, so every entry to WAIT starts from a clean count.
  assign wd_clear  = (state_q != WB_WAIT) || wb_flush;
  assign wd_enable = (state_q == WB_WAIT) && !src_ready && !wb_flush;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= WB_IDLE;
      seletor_q   <= WB_ALU;
      write_reg_q <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (wb_flush) begin
        state_q <= WB_IDLE;
      end else begin
        unique case (state_q)
          WB_IDLE: begin
            if (wb_req) begin
              seletor_q   <= wb_src;
              write_reg_q <= wb_dst;
              if (!wb_src_legal(wb_src)) begin
                err_q <= 1'b1;
              end else if (wb_src_waits(wb_src)) begin
                state_q <= WB_WAIT;
              end else begin
                state_q <= WB_WRITE;
              end
            end
          end
          WB_WAIT: begin
            // A ready source wins over a coincident watchdog expiry.
            if (src_ready) begin
              state_q <= WB_WRITE;
            end else if (wd_expired) begin
              state_q <= WB_IDLE;
              err_q   <= 1'b1;
            end
          end
          WB_WRITE: state_q <= WB_IDLE;
          default:  state_q <= WB_IDLE;
        endcase
      end
    end
  end

  assign seletor   = seletor_q;
  assign write_reg = write_reg_q;
  assign busy      = (state_q != WB_IDLE);

  // Strobes are gated by reset and flush so an aborted request never reaches the register file.
  assign wb_ack    = reset && (state_q == WB_IDLE) && wb_req && !wb_flush;
  assign reg_write = reset && (state_q == WB_WRITE) && (write_reg_q != 5'd0) && !wb_flush;
  assign wb_done   = reset && (state_q == WB_WRITE) && !wb_flush;
  assign wb_err    = reset && err_q && !wb_flush;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: cycle-scripted requests with a write scoreboard that
// matches every register-file write against the requests that should produce one.
module tb_wb_sequencer;

  localparam int unsigned Timeout = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_req;
  logic [3:0] wb_src;
  logic [4:0] wb_dst;
  logic       wb_flush;
  logic       mem_ready;
  logic       muldiv_done;
  logic       shift_done;
  logic       wb_ack;
  logic       busy;
  logic [3:0] seletor;
  logic       reg_write;
  logic [4:0] write_reg;
  logic       wb_done;
  logic       wb_err;

  int n_checks  = 0;
  int n_errors  = 0;
  int write_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  logic [8:0] exp_q[$];

  wb_sequencer #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_req      (wb_req),
    .wb_src      (wb_src),
    .wb_dst      (wb_dst),
    .wb_flush    (wb_flush),
    .mem_ready   (mem_ready),
    .muldiv_done (muldiv_done),
    .shift_done  (shift_done),
    .wb_ack      (wb_ack),
    .busy        (busy),
    .seletor     (seletor),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .wb_done     (wb_done),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic accept(input logic [3:0] src, input logic [4:0] dst, input logic exp_wr);
    wb_req = 1'b1;
    wb_src = src;
    wb_dst = dst;
    settle();
    check_eq("ack", 32'(wb_ack), 1);
    if (exp_wr) exp_q.push_back({src, dst});
  endtask

  // Scoreboard: every write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reg_write) begin
      write_cnt++;
      check_eq("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("write_sel_dst", 32'({seletor, write_reg}), 32'(exp_q.pop_front()));
      end
    end
    if (wb_done) done_cnt++;
    if (wb_err) err_cnt++;
  end

  initial begin
    int w0;
    reset = 1'b0;
    wb_req = 1'b1;
    wb_src = 4'd0;
    wb_dst = 5'd1;
    wb_flush = 1'b0;
    mem_ready = 1'b0;
    muldiv_done = 1'b0;
    shift_done = 1'b0;
    cyc();
    cyc();
    settle();
    check_eq("rst_ack", 32'(wb_ack), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_sel", 32'(seletor), 0);
    check_eq("rst_wreg", 32'(write_reg), 0);
    check_eq("rst_rw", 32'(reg_write), 0);
    check_eq("rst_done", 32'(wb_done), 0);
    check_eq("rst_err", 32'(wb_err), 0);
    cyc();
    reset = 1'b1;
    wb_req = 1'b0;
    settle();

    // Immediate ALU write.
    cyc(); accept(4'd0, 5'd8, 1'b1);
    check_eq("t1_busy_T", 32'(busy), 0);
    cyc(); wb_req = 1'b0; settle();
    check_eq("t1_rw", 32'(reg_write), 1);
    check_eq("t1_done", 32'(wb_done), 1);
    check_eq("t1_sel", 32'(seletor), 0);
    check_eq("t1_wreg", 32'(write_reg), 8);
    cyc(); settle();
    check_eq("t1_idle", 32'(busy), 0);
    check_eq("t1_rw_off", 32'(reg_write), 0);

    // Load with three cycles of memory latency.
    w0 = write_cnt;
    cyc(); accept(4'd1, 5'd5, 1'b1);
    cyc(); wb_req = 1'b0; settle();
    check_eq("t2_busy", 32'(busy), 1);
    check_eq("t2_sel_wait", 32'(seletor), 1);
    check_eq("t2_rw_w1", 32'(reg_write), 0);
    cyc(); settle();
    check_eq("t2_rw_w2", 32'(reg_write), 0);
    cyc(); mem_ready = 1'b1; settle();
    check_eq("t2_rw_w3", 32'(reg_write), 0);
    cyc(); mem_ready = 1'b0; settle();
    check_eq("t2_rw", 32'(reg_write), 1);
    check_eq("t2_sel_wr", 32'(seletor), 1);
    check_eq("t2_wreg", 32'(write_reg), 5);
    cyc(); settle();
    check_eq("t2_idle", 32'(busy), 0);
    check_eq("t2_sel_held", 32'(seletor), 1);
    check_eq("t2_one_write", 32'(write_cnt - w0), 1);

    // r0 destination: completes without writing.
    cyc(); accept(4'd9, 5'd0, 1'b0);
    cyc(); wb_req = 1'b0; settle();
    check_eq("t3_done", 32'(wb_done), 1);
    check_eq("t3_rw", 32'(reg_write), 0);

    // Illegal source.
    cyc(); accept(4'd12, 5'd3, 1'b0);
    check_eq("t3_ill_busy_T", 32'(busy), 0);
    cyc(); wb_req = 1'b0; settle();
    check_eq("t3_ill_err", 32'(wb_err), 1);
    check_eq("t3_ill_busy", 32'(busy), 0);
    check_eq("t3_ill_rw", 32'(reg_write), 0);
    cyc(); settle();
    check_eq("t3_ill_err_off", 32'(wb_err), 0);

    // Timeout on HI with muldiv_done held low.
    cyc(); accept(4'd3, 5'd7, 1'b0);
    for (int k = 1; k <= Timeout; k++) begin
      cyc(); wb_req = 1'b0; settle();
      check_eq("t4_err_early", 32'(wb_err), 0);
      check_eq("t4_busy", 32'(busy), 1);
    end
    cyc(); settle();
    check_eq("t4_err", 32'(wb_err), 1);
    check_eq("t4_idle", 32'(busy), 0);
    cyc(); settle();
    check_eq("t4_err_off", 32'(wb_err), 0);

    // Flush while waiting; a late ready must not revive the request.
    cyc(); accept(4'd4, 5'd9, 1'b0);
    cyc(); wb_req = 1'b0; wb_flush = 1'b1; settle();
    check_eq("t5a_done", 32'(wb_done), 0);
    check_eq("t5a_err", 32'(wb_err), 0);
    cyc(); wb_flush = 1'b0; shift_done = 1'b1; settle();
    check_eq("t5a_idle", 32'(busy), 0);
    cyc(); shift_done = 1'b0; settle();
    check_eq("t5a_rw", 32'(reg_write), 0);

    // Flush coincident with WRITE.
    cyc(); accept(4'd10, 5'd4, 1'b0);
    cyc(); wb_req = 1'b0; wb_flush = 1'b1; settle();
    check_eq("t5b_rw", 32'(reg_write), 0);
    check_eq("t5b_done", 32'(wb_done), 0);
    cyc(); wb_flush = 1'b0; settle();
    check_eq("t5b_idle", 32'(busy), 0);

    // Back-pressure: second request held while the first one is in flight.
    cyc(); accept(4'd2, 5'd6, 1'b1);
    cyc(); wb_src = 4'd5; wb_dst = 5'd11; settle();
    check_eq("t5c_ack_wait1", 32'(wb_ack), 0);
    check_eq("t5c_sel_held", 32'(seletor), 2);
    cyc(); muldiv_done = 1'b1; settle();
    check_eq("t5c_ack_wait2", 32'(wb_ack), 0);
    cyc(); muldiv_done = 1'b0; settle();
    check_eq("t5c_ack_write", 32'(wb_ack), 0);
    check_eq("t5c_rw1", 32'(reg_write), 1);
    cyc(); accept(4'd5, 5'd11, 1'b1);
    cyc(); wb_req = 1'b0; settle();
    check_eq("t5c_rw2", 32'(reg_write), 1);
    check_eq("t5c_wreg2", 32'(write_reg), 11);
    cyc(); settle();
    check_eq("t5c_idle", 32'(busy), 0);

    // Reset during WAIT drops the request.
    cyc(); accept(4'd1, 5'd12, 1'b0);
    cyc(); wb_req = 1'b0; reset = 1'b0; settle();
    check_eq("t6_rw_in_rst", 32'(reg_write), 0);
    cyc(); reset = 1'b1; mem_ready = 1'b1; settle();
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_sel", 32'(seletor), 0);
    check_eq("t6_wreg", 32'(write_reg), 0);
    check_eq("t6_rw", 32'(reg_write), 0);
    check_eq("t6_done", 32'(wb_done), 0);
    check_eq("t6_err", 32'(wb_err), 0);
    cyc(); mem_ready = 1'b0; settle();
    check_eq("t6_rw_after", 32'(reg_write), 0);
    check_eq("t6_busy_after", 32'(busy), 0);

    cyc();
    cyc(); settle();
    check_eq("total_writes", 32'(write_cnt), 4);
    check_eq("total_done", 32'(done_cnt), 5);
    check_eq("total_err", 32'(err_cnt), 2);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
